baud_tick_gen: RTL and testbench
================================

Name: baud_tick_gen

Overview:
- Second-generation baud tick source for the UART RX/TX paths.
- Replaces the fixed compile-time divisor with a runtime-loadable integer+fractional divisor.
- Provides two independent channels (RX, TX), each with its own phase alignment and enable.
- Each channel emits an oversample tick plus a bit tick (one per SAMPLE_RATE oversample ticks), so RX sampling and TX shifting need no local counters.

Parameters:
- CLK_HZ, 25_000_000, system clock frequency in Hz.
- DEFAULT_BAUD, 9600, baud rate loaded at reset.
- SAMPLE_RATE, 16, oversample ticks per bit; power of two, >= 4.
- DIV_W, 16, width of the integer divisor and the period counters.
- FRAC_W, 4, width of the fractional divisor and accumulator.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- div_int  in  DIV_W  integer part of the clocks-per-oversample-tick divisor.
- div_frac  in  FRAC_W  fractional part, in units of 1/2^FRAC_W.
- div_load  in  1  capture div_int/div_frac into the shadow divisor.
- rx_en  in  1  RX channel run enable.
- start_rx  in  1  align the RX channel to a start-bit edge.
- tx_en  in  1  TX channel run enable.
- start_tx  in  1  align the TX channel to a bit start.
- rx_tick  out  1  RX oversample tick, 1-cycle pulse.
- rx_bit  out  1  RX bit-centre tick, 1-cycle pulse, coincident with an rx_tick.
- tx_tick  out  1  TX oversample tick, 1-cycle pulse.
- tx_bit  out  1  TX bit-boundary tick, 1-cycle pulse, coincident with a tx_tick.

Behaviour:
- Reset:
  - Divisor register loads DIV_INT_DEFAULT = CLK_HZ/(DEFAULT_BAUD*SAMPLE_RATE).
  - Fractional part loads DIV_FRAC_DEFAULT = ((CLK_HZ<<FRAC_W)/(DEFAULT_BAUD*SAMPLE_RATE)) mod 2^FRAC_W.
  - All counters and accumulators clear to 0; all outputs are 0.
- Divisor:
  - div_load writes the shadow register; each channel adopts it at its next wrap or start, never mid-period.
  - div_int < 2 is clamped to 2.
- Channel state: period counter cnt (DIV_W), fractional accumulator acc (FRAC_W), carry bit cy, sub-tick counter sub (log2 SAMPLE_RATE).
- Period: P = div_int + cy.
- Tick:
  - *_tick = en && cnt == P-1 (combinational decode of registered state).
  - On a tick: cnt <= 0; {cy, acc} <= acc + div_frac; sub <= sub+1, wrapping mod SAMPLE_RATE.
  - Otherwise cnt <= cnt+1.
- Bit tick: *_bit = *_tick && sub == SAMPLE_RATE-1.
- Long-run average tick period = div_int + div_frac/2^FRAC_W clocks.
- Enable low: cnt, acc, cy and sub hold; no ticks. Raising enable resumes from the held state.
- start_tx: cnt <= 0, acc <= 0, cy <= 0, sub <= 0.
  - First tx_tick is P clocks after the start edge.
  - First tx_bit is one full bit later.
- start_rx: cnt <= 0, acc <= 0, cy <= 0, sub <= SAMPLE_RATE/2.
  - First rx_bit comes SAMPLE_RATE/2 ticks later, i.e. mid start-bit.
  - Subsequent rx_bit pulses fall at bit centres.
- start_* acts regardless of *_en. While en is low the channel stays aligned and held.
- Priority: reset > start > tick/wrap > increment.
- div_load coincident with start_*: start uses the newly loaded divisor.
- start_* coincident with a would-be tick: the tick is suppressed.
- The RX and TX channels are fully independent; the same cycle may carry ticks on both.

Optional Feature:
- Macro: BAUD_TICK_FRAC_EN.
- Defined: fractional accumulator present, as described above.
- Undefined: acc and cy are not built; div_frac is ignored; P = div_int exactly; DIV_FRAC_DEFAULT is unused.

Decomposition:
- Package baud_pkg:
  - typedef struct baud_div_t {div_int, div_frac}.
  - Functions calc_div_int() and calc_div_frac().
  - Default-divisor constants.
- Sub-module baud_tick_channel:
  - Holds one channel's cnt/acc/cy/sub state.
  - Inputs: divisor, en, start, sub_init.
  - Outputs: tick, bit.
  - Instantiated twice: RX with sub_init = SAMPLE_RATE/2, TX with sub_init = 0.

Test Plan:
1. Reset with defaults (25 MHz, 9600, 16x, FRAC_W=4) -> divisor reads 162/12; all ticks 0; no ticks while rx_en=tx_en=0.
2. Load 4/0, tx_en=1, pulse start_tx at edge k -> tx_tick at cycles k+4, k+8, ...; first tx_bit at k+64, then every 64.
3. Load 4/8, start_tx -> tick spacings 4,4,5,4,5,...; with the macro off, spacings are constantly 4.
4. Load 4/0, rx_en=1, start_rx at edge k -> rx_tick every 4 cycles; first rx_bit at k+32, then k+96, k+160.
5. Running at 4/0, div_load 6/0 mid-period -> current period ends at 4; following spacings are 6. div_load 1/0 -> spacing 2 (clamp).
6. Reset mid-bit with both channels running -> next cycle all outputs 0; divisor back to 162/12; start_tx + start_rx with tick pending -> tick suppressed, both re-aligned.

Source files
------------

// File: rtl/baud_pkg.sv
// Shared types and helpers for the baud tick generator.
//   baud_div_t      : integer + fractional clocks-per-oversample-tick divisor
//   calc_div_int()  : integer divisor from clock / baud / oversample rate
//   calc_div_frac() : fractional divisor in units of 1/2^frac_w
// Package defaults mirror the top-level parameter defaults.
package baud_pkg;

    localparam int unsigned BAUD_DIV_W               = 16;
    localparam int unsigned BAUD_FRAC_W              = 4;
    localparam int unsigned BAUD_CLK_HZ_DEFAULT      = 25_000_000;
    localparam int unsigned BAUD_RATE_DEFAULT        = 9600;
    localparam int unsigned BAUD_SAMPLE_RATE_DEFAULT = 16;

    typedef struct packed {
        logic [BAUD_DIV_W-1:0]  div_int;
        logic [BAUD_FRAC_W-1:0] div_frac;
    } baud_div_t;

    function automatic int unsigned calc_div_int(int unsigned clk_hz, int unsigned baud,
                                                 int unsigned sample_rate);
        return clk_hz / (baud * sample_rate);
    endfunction

    // 64-bit intermediate so clk_hz << frac_w cannot overflow.
    function automatic int unsigned calc_div_frac(int unsigned clk_hz, int unsigned baud,
                                                  int unsigned sample_rate, int unsigned frac_w);
        logic [63:0] num;
        logic [63:0] den;
        logic [63:0] quo;
        num = 64'(clk_hz) << frac_w;
        den = 64'(baud) * 64'(sample_rate);
        quo = num / den;
        return 32'(quo & ((64'd1 << frac_w) - 64'd1));
    endfunction

    localparam int unsigned BAUD_DIV_INT_DEFAULT =
        calc_div_int(BAUD_CLK_HZ_DEFAULT, BAUD_RATE_DEFAULT, BAUD_SAMPLE_RATE_DEFAULT);
    localparam int unsigned BAUD_DIV_FRAC_DEFAULT =
        calc_div_frac(BAUD_CLK_HZ_DEFAULT, BAUD_RATE_DEFAULT, BAUD_SAMPLE_RATE_DEFAULT,
                      BAUD_FRAC_W);

endpackage

// File: rtl/baud_tick_gen_if.sv
// Control/status bundle of the baud tick generator.
//   master : drives divisor load, enables and start strobes; receives ticks
//   slave  : the generator itself
interface baud_tick_gen_if
    import baud_pkg::*;
#(
    parameter int unsigned DIV_W  = BAUD_DIV_W,
    parameter int unsigned FRAC_W = BAUD_FRAC_W
);

    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_load;
    logic              rx_en;
    logic              start_rx;
    logic              tx_en;
    logic              start_tx;
    logic              rx_tick;
    logic              rx_bit;
    logic              tx_tick;
    logic              tx_bit;

    modport master (
        output div_int, div_frac, div_load, rx_en, start_rx, tx_en, start_tx,
        input  rx_tick, rx_bit, tx_tick, tx_bit
    );

    modport slave (
        input  div_int, div_frac, div_load, rx_en, start_rx, tx_en, start_tx,
        output rx_tick, rx_bit, tx_tick, tx_bit
    );

endinterface

// File: rtl/baud_tick_channel.sv
// One baud tick channel: period counter, optional fractional accumulator and
// oversample sub-counter.
//   clock, reset : system clock, synchronous active-high reset
//   div          : divisor to adopt at the next wrap or start
//   en           : run enable; low holds all state
//   start        : realign (cnt/acc/cy cleared, sub loaded with sub_init)
//   sub_init     : sub-counter value loaded on start
//   tick         : oversample tick pulse
//   bit_tick     : tick that closes a group of SAMPLE_RATE oversample ticks
// Macro BAUD_TICK_FRAC_EN builds the fractional accumulator; otherwise the
// period is exactly the integer divisor.
module baud_tick_channel
    import baud_pkg::*;
#(
    parameter int unsigned  SAMPLE_RATE = BAUD_SAMPLE_RATE_DEFAULT,
    parameter int unsigned  DIV_INT_RST = BAUD_DIV_INT_DEFAULT,
    localparam int unsigned SUB_W       = $clog2(SAMPLE_RATE)
) (
    input  logic             clock,
    input  logic             reset,
    input  baud_div_t        div,
    input  logic             en,
    input  logic             start,
    input  logic [SUB_W-1:0] sub_init,
    output logic             tick,
    output logic             bit_tick
);

    localparam int unsigned DIV_W  = BAUD_DIV_W;

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] div_q;    // integer divisor in force for the current period
    logic [SUB_W-1:0] sub_q;
    logic [DIV_W:0]   period_m1;
    logic             wrap;

`ifdef BAUD_TICK_FRAC_EN
    localparam int unsigned FRAC_W = BAUD_FRAC_W;

    logic [FRAC_W-1:0] acc_q;
    logic              cy_q;
    logic [FRAC_W:0]   acc_sum;

    assign acc_sum   = {1'b0, acc_q} + {1'b0, div.div_frac};
    // One extra bit so div_int + cy cannot overflow at the top of the range.
    assign period_m1 = {1'b0, div_q} + {{DIV_W{1'b0}}, cy_q} - (DIV_W+1)'(1);
`else
    logic unused_frac;
    assign unused_frac = ^div.div_frac;
    assign period_m1   = {1'b0, div_q} - (DIV_W+1)'(1);
`endif

    // A start in the same cycle swallows the tick it would otherwise produce.
    assign wrap     = en && !start && ({1'b0, cnt_q} == period_m1);
    assign tick     = wrap;
    assign bit_tick = wrap && (sub_q == SUB_W'(SAMPLE_RATE - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
            div_q <= DIV_W'(DIV_INT_RST);
            sub_q <= '0;
`ifdef BAUD_TICK_FRAC_EN
            acc_q <= '0;
            cy_q  <= 1'b0;
`endif
        end else if (start) begin
            cnt_q <= '0;
            div_q <= div.div_int;
            sub_q <= sub_init;
`ifdef BAUD_TICK_FRAC_EN
            acc_q <= '0;
            cy_q  <= 1'b0;
`endif
        end else if (wrap) begin
            cnt_q <= '0;
            div_q <= div.div_int;
            sub_q <= sub_q + SUB_W'(1);   // power-of-two rate: wraps naturally
`ifdef BAUD_TICK_FRAC_EN
            {cy_q, acc_q} <= acc_sum;
`endif
        end else if (en) begin
            cnt_q <= cnt_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/baud_tick_gen.sv
// Two-channel (RX/TX) baud tick generator with a runtime-loadable divisor.
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : div_int/div_frac/div_load shadow divisor load,
//                  rx_en/start_rx and tx_en/start_tx channel control,
//                  rx_tick/rx_bit and tx_tick/tx_bit tick outputs
// RX aligns its sub-counter to half a bit so rx_bit lands mid-bit; TX aligns
// to zero so tx_bit marks bit boundaries.
// Macro BAUD_TICK_FRAC_EN enables the fractional divisor.
module baud_tick_gen
    import baud_pkg::*;
#(
    parameter int unsigned CLK_HZ       = BAUD_CLK_HZ_DEFAULT,
    parameter int unsigned DEFAULT_BAUD = BAUD_RATE_DEFAULT,
    parameter int unsigned SAMPLE_RATE  = BAUD_SAMPLE_RATE_DEFAULT,
    parameter int unsigned DIV_W        = BAUD_DIV_W,
    parameter int unsigned FRAC_W       = BAUD_FRAC_W
) (
    input logic           clock,
    input logic           reset,
    baud_tick_gen_if.slave bus
);

    localparam int unsigned SUB_W           = $clog2(SAMPLE_RATE);
    localparam int unsigned DIV_INT_DEFAULT =
        calc_div_int(CLK_HZ, DEFAULT_BAUD, SAMPLE_RATE);
`ifdef BAUD_TICK_FRAC_EN
    localparam int unsigned DIV_FRAC_DEFAULT =
        calc_div_frac(CLK_HZ, DEFAULT_BAUD, SAMPLE_RATE, FRAC_W);
`endif

    baud_div_t shadow_q;
    baud_div_t shadow_d;

    // Channels see shadow_d so a load coincident with start/wrap takes effect.
    always_comb begin
        shadow_d = shadow_q;
        if (bus.div_load) begin
            shadow_d.div_int  = (bus.div_int < DIV_W'(2)) ? DIV_W'(2) : bus.div_int;
            shadow_d.div_frac = bus.div_frac;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_q.div_int  <= DIV_W'(DIV_INT_DEFAULT);
`ifdef BAUD_TICK_FRAC_EN
            shadow_q.div_frac <= FRAC_W'(DIV_FRAC_DEFAULT);
`else
            shadow_q.div_frac <= FRAC_W'(0);
`endif
        end else begin
            shadow_q <= shadow_d;
        end
    end

    baud_tick_channel #(
        .SAMPLE_RATE (SAMPLE_RATE),
        .DIV_INT_RST (DIV_INT_DEFAULT)
    ) u_rx (
        .clock    (clock),
        .reset    (reset),
        .div      (shadow_d),
        .en       (bus.rx_en),
        .start    (bus.start_rx),
        .sub_init (SUB_W'(SAMPLE_RATE / 2)),
        .tick     (bus.rx_tick),
        .bit_tick (bus.rx_bit)
    );

    baud_tick_channel #(
        .SAMPLE_RATE (SAMPLE_RATE),
        .DIV_INT_RST (DIV_INT_DEFAULT)
    ) u_tx (
        .clock    (clock),
        .reset    (reset),
        .div      (shadow_d),
        .en       (bus.tx_en),
        .start    (bus.start_tx),
        .sub_init (SUB_W'(0)),
        .tick     (bus.tx_tick),
        .bit_tick (bus.tx_bit)
    );

endmodule

// File: tb/tb_baud_tick_gen.sv
// Self-checking bench for baud_tick_gen: directed scenarios followed by a
// randomized run, all checked cycle by cycle against a countdown model.
module tb_baud_tick_gen;

    localparam int SR       = 16;
    localparam int DEF_INT  = 162;
    localparam int DEF_FRAC = 12;
`ifdef BAUD_TICK_FRAC_EN
    localparam int FRAC_ON = 1;
`else
    localparam int FRAC_ON = 0;
`endif

    logic clock;
    logic reset;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    baud_tick_gen_if #(.DIV_W(16), .FRAC_W(4)) bus ();

    baud_tick_gen #(
        .CLK_HZ       (25_000_000),
        .DEFAULT_BAUD (9600),
        .SAMPLE_RATE  (16),
        .DIV_W        (16),
        .FRAC_W       (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp;
    int n_fail;
    int cyc;

    // Model per channel (0 = RX, 1 = TX): clocks left until the next tick,
    // fractional remainder, ticks since alignment, sub phase at alignment.
    int rem [2];
    int racc[2];
    int nt  [2];
    int base[2];
    int sh_int;
    int sh_frac;
    int start_cyc[2];

    int tx_t[$];
    int tx_bit_t[$];
    int rx_bit_t[$];

    function automatic int tick_time(int n, int di, int df);
        return n * di + ((n - 1) * df * FRAC_ON) / 16;
    endfunction

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic void model_reset();
        sh_int  = DEF_INT;
        sh_frac = DEF_FRAC;
        for (int c = 0; c < 2; c++) begin
            rem[c]  = DEF_INT;
            racc[c] = 0;
            nt[c]   = 0;
            base[c] = 0;
        end
    endfunction

    function automatic logic exp_tick(int c, logic en, logic st);
        return en && !st && (rem[c] == 1);
    endfunction

    function automatic logic exp_bit(int c, logic en, logic st);
        return exp_tick(c, en, st) && (((base[c] + nt[c]) % SR) == SR - 1);
    endfunction

    task automatic check_bit(string tag, logic obs, logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_int(string tag, int obs, int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        tx_t.delete();
        tx_bit_t.delete();
        rx_bit_t.delete();
    endtask

    // One clock: compare outputs mid-cycle, then advance the model on the edge.
    task automatic step();
        logic [1:0] en;
        logic [1:0] st;
        logic [1:0] tk;
        en = {bus.tx_en, bus.rx_en};
        st = {bus.start_tx, bus.start_rx};
        #1;
        check_bit("rx_tick", bus.rx_tick, exp_tick(0, en[0], st[0]));
        check_bit("rx_bit",  bus.rx_bit,  exp_bit(0, en[0], st[0]));
        check_bit("tx_tick", bus.tx_tick, exp_tick(1, en[1], st[1]));
        check_bit("tx_bit",  bus.tx_bit,  exp_bit(1, en[1], st[1]));
        if (bus.tx_tick === 1'b1) tx_t.push_back(cyc + 1 - start_cyc[1]);
        if (bus.tx_bit === 1'b1)  tx_bit_t.push_back(cyc + 1 - start_cyc[1]);
        if (bus.rx_bit === 1'b1)  rx_bit_t.push_back(cyc + 1 - start_cyc[0]);
        @(posedge clock);
        cyc++;
        if (reset) begin
            model_reset();
        end else begin
            for (int c = 0; c < 2; c++) tk[c] = exp_tick(c, en[c], st[c]);
            if (bus.div_load) begin
                sh_int  = (int'(bus.div_int) < 2) ? 2 : int'(bus.div_int);
                sh_frac = int'(bus.div_frac);
            end
            for (int c = 0; c < 2; c++) begin
                if (st[c]) begin
                    rem[c]       = sh_int;
                    racc[c]      = 0;
                    nt[c]        = 0;
                    base[c]      = (c == 0) ? SR / 2 : 0;
                    start_cyc[c] = cyc;
                end else if (tk[c]) begin
                    racc[c] = racc[c] + sh_frac * FRAC_ON;
                    rem[c]  = sh_int + racc[c] / 16;
                    racc[c] = racc[c] % 16;
                    nt[c]++;
                end else if (en[c]) begin
                    rem[c]--;
                end
            end
        end
        @(negedge clock);
    endtask

    task automatic load(int di, int df);
        bus.div_int  = 16'(di);
        bus.div_frac = 4'(df);
        bus.div_load = 1'b1;
    endtask

    initial begin
        int guard;
        n_cmp        = 0;
        n_fail       = 0;
        cyc          = 0;
        start_cyc[0] = 0;
        start_cyc[1] = 0;
        reset        = 1'b1;
        bus.div_int  = '0;
        bus.div_frac = '0;
        bus.div_load = 1'b0;
        bus.rx_en    = 1'b0;
        bus.start_rx = 1'b0;
        bus.tx_en    = 1'b0;
        bus.start_tx = 1'b0;
        model_reset();
        @(posedge clock);
        @(negedge clock);
        step();
        step();
        reset = 1'b0;

        // Idle: no ticks with both enables low.
        repeat (100) step();

        // Default divisor seen through TX tick spacing.
        bus.tx_en    = 1'b1;
        bus.start_tx = 1'b1;
        step();
        bus.start_tx = 1'b0;
        clear_q();
        repeat (2620) step();
        for (int i = 0; i < 4; i++)
            check_int("dflt_tick", qat(tx_t, i), tick_time(i + 1, DEF_INT, DEF_FRAC));
        check_int("dflt_bit", qat(tx_bit_t, 0), tick_time(16, DEF_INT, DEF_FRAC));

        // 4/0 with start_tx: ticks every 4, bits every 64.
        load(4, 0);
        bus.start_tx = 1'b1;
        step();
        bus.div_load = 1'b0;
        bus.start_tx = 1'b0;
        clear_q();
        repeat (140) step();
        for (int i = 0; i < 3; i++) check_int("tx4_tick", qat(tx_t, i), 4 * (i + 1));
        check_int("tx4_bit0", qat(tx_bit_t, 0), 64);
        check_int("tx4_bit1", qat(tx_bit_t, 1), 128);

        // 4/8: fractional spacing.
        load(4, 8);
        bus.start_tx = 1'b1;
        step();
        bus.div_load = 1'b0;
        bus.start_tx = 1'b0;
        clear_q();
        repeat (30) step();
        for (int i = 0; i < 5; i++) check_int("frac_tick", qat(tx_t, i), tick_time(i + 1, 4, 8));

        // RX alignment: first bit at mid start-bit.
        load(4, 0);
        bus.rx_en    = 1'b1;
        bus.start_rx = 1'b1;
        step();
        bus.div_load = 1'b0;
        bus.start_rx = 1'b0;
        clear_q();
        repeat (170) step();
        check_int("rx_bit0", qat(rx_bit_t, 0), 32);
        check_int("rx_bit1", qat(rx_bit_t, 1), 96);
        check_int("rx_bit2", qat(rx_bit_t, 2), 160);

        // Divisor change mid-period, then clamp of 1 to 2.
        load(4, 0);
        bus.start_tx = 1'b1;
        step();
        bus.div_load = 1'b0;
        bus.start_tx = 1'b0;
        clear_q();
        repeat (5) step();
        load(6, 0);
        step();
        bus.div_load = 1'b0;
        repeat (14) step();
        load(1, 0);
        step();
        bus.div_load = 1'b0;
        repeat (10) step();
        check_int("chg_t0", qat(tx_t, 0), 4);
        check_int("chg_t1", qat(tx_t, 1), 8);
        check_int("chg_t2", qat(tx_t, 2), 14);
        check_int("chg_t3", qat(tx_t, 3), 20);
        check_int("clamp_t4", qat(tx_t, 4), 26);
        check_int("clamp_t5", qat(tx_t, 5), 28);
        check_int("clamp_t6", qat(tx_t, 6), 30);

        // Reset mid-bit with both channels running.
        repeat (7) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_bit("rst_rx_tick", bus.rx_tick, 1'b0);
        check_bit("rst_rx_bit",  bus.rx_bit,  1'b0);
        check_bit("rst_tx_tick", bus.tx_tick, 1'b0);
        check_bit("rst_tx_bit",  bus.tx_bit,  1'b0);

        // Start both with a tick pending: tick swallowed, channels realigned.
        guard = 0;
        while (rem[1] != 1 && guard < 400) begin
            step();
            guard++;
        end
        check_int("pend_found", int'(guard < 400), 1);
        check_bit("pend_tx_tick", bus.tx_tick, 1'b1);
        bus.start_tx = 1'b1;
        bus.start_rx = 1'b1;
        #1;
        check_bit("supp_tx_tick", bus.tx_tick, 1'b0);
        check_bit("supp_rx_tick", bus.rx_tick, 1'b0);
        step();
        bus.start_tx = 1'b0;
        bus.start_rx = 1'b0;
        clear_q();
        repeat (1310) step();
        check_int("realign_tx", qat(tx_t, 0), tick_time(1, DEF_INT, DEF_FRAC));
        check_int("realign_rx", qat(rx_bit_t, 0), tick_time(8, DEF_INT, DEF_FRAC));

        // Randomized traffic against the model.
        for (int i = 0; i < 6000; i++) begin
            bus.rx_en    = ($urandom_range(0, 9) != 0);
            bus.tx_en    = ($urandom_range(0, 9) != 0);
            bus.start_rx = ($urandom_range(0, 99) == 0);
            bus.start_tx = ($urandom_range(0, 99) == 0);
            bus.div_load = ($urandom_range(0, 49) == 0);
            bus.div_int  = 16'($urandom_range(0, 7));
            bus.div_frac = 4'($urandom_range(0, 15));
            reset        = ($urandom_range(0, 1999) == 0);
            step();
        end
        reset        = 1'b0;
        bus.div_load = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
